mem_access_arbiter: RTL and testbench

//  Shares the single-port 256x8 data memory between two requesters: port A (pipeline MEM stage)
//  and port B (debug/loader). Round-robin arbitration, one outstanding access.

---
 rtl/mem_access_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_access_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter that shares a single-port synchronous-read data memory between port A
// (pipeline MEM stage) and port B (debug/loader). Only one access is outstanding at a time:
// accept -> memory enable cycle -> response cycle.
module mem_access_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req_valid,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_req_ready,
  output logic              a_rsp_valid,
  output logic [DATA_W-1:0] a_rsp_rdata,

  input  logic              b_req_valid,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_req_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_rdata,

  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic              last_b_q, last_b_d;    // 1: B won the most recent grant
  logic              owner_b_q, owner_b_d;  // 1: outstanding access belongs to B
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              can_accept;
  logic              grant_a;
  logic              grant_b;

  // Arbitration: a new access may start only from IDLE or RESP, and never while reset is held.
  always_comb begin
    can_accept = reset && ((state_q == StIdle) || (state_q == StResp));
    grant_a    = can_accept && a_req_valid && (!b_req_valid || last_b_q);
    grant_b    = can_accept && b_req_valid && !grant_a;
  end

  // Next-state logic and capture of the winning request's fields.
  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    owner_b_d = owner_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant_a || grant_b) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        state_d = StResp;
      end
      StResp: begin
        state_d = (grant_a || grant_b) ? StAccess : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (grant_a) begin
      last_b_d  = 1'b0;
      owner_b_d = 1'b0;
      we_d      = a_req_write;
      addr_d    = a_req_addr;
      wdata_d   = a_req_wdata;
    end else if (grant_b) begin
      last_b_d  = 1'b1;
      owner_b_d = 1'b1;
      we_d      = b_req_write;
      addr_d    = b_req_addr;
      wdata_d   = b_req_wdata;
    end
  end

  // State register; reset leaves last_b set so A wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      owner_b_q <= owner_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Output decode: memory side comes only from registered state, so no request-to-memory path.
  always_comb begin
    a_req_ready = grant_a;
    b_req_ready = grant_b;
    MemRead     = (state_q == StAccess) && !we_q;
    MemWrite    = (state_q == StAccess) && we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    busy        = (state_q != StIdle);
    // A response pending at a reset edge is dropped rather than delivered.
    a_rsp_valid = reset && (state_q == StResp) && !owner_b_q;
    b_rsp_valid = reset && (state_q == StResp) && owner_b_q;
    a_rsp_rdata = (a_rsp_valid && !we_q) ? mem_rdata : '0;
    b_rsp_rdata = (b_rsp_valid && !we_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a transaction-level model of the arbiter and memory.
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req_valid, a_req_write, a_req_ready, a_rsp_valid;
  logic [7:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic       b_req_valid, b_req_write, b_req_ready, b_rsp_valid;
  logic [7:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic       MemRead, MemWrite, busy;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] mem [256] = '{default: 8'h00};

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_req_valid (a_req_valid),
    .a_req_write (a_req_write),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .a_req_ready (a_req_ready),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_req_valid (b_req_valid),
    .b_req_write (b_req_write),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .b_req_ready (b_req_ready),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
  );

  // Data memory: no reset, 1-cycle registered read.
  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr] <= mem_wdata;
    if (MemRead)  mem_rdata <= mem[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  req_t aq[$];
  req_t bq[$];
  bit   rand_en = 1'b0;
  bit   chk_en = 1'b0;

  // Observations collected by the checker for the directed scenarios.
  int         a_rsp_cnt = 0, b_rsp_cnt = 0, a_acc_cnt = 0, b_acc_cnt = 0;
  int         a_acc_cyc = 0, b_acc_cyc = 0, a_lat = 0, b_lat = 0;
  logic [7:0] a_rd_seen = 8'h00, b_rd_seen = 8'h00;
  bit         grants[$];
  int         rsp_cycs[$];

  // Reference model: one outstanding transaction, enables at accept+1, response at accept+2.
  int         cyc = 0, pend_cyc = 0;
  bit         pend = 1'b0, pend_b = 1'b0, pend_we = 1'b0, last_b = 1'b1;
  bit         can, ga, gb, acc_ph, rsp_ph, exp_av, exp_bv;
  logic [7:0] pend_wd = 8'h00, pend_rd = 8'h00, exp_rd, exp_addr = 8'h00;
  logic [7:0] ref_mem [256];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cyc++;
        can    = reset && (!pend || (cyc == pend_cyc + 2));
        ga     = can && a_req_valid && (!b_req_valid || last_b);
        gb     = can && b_req_valid && !ga;
        acc_ph = pend && (cyc == pend_cyc + 1);
        rsp_ph = pend && (cyc == pend_cyc + 2);
        exp_av = reset && rsp_ph && !pend_b;
        exp_bv = reset && rsp_ph && pend_b;
        exp_rd = pend_we ? 8'h00 : pend_rd;

        check("a_req_ready", 8'(a_req_ready), 8'(ga));
        check("b_req_ready", 8'(b_req_ready), 8'(gb));
        check("a_rsp_valid", 8'(a_rsp_valid), 8'(exp_av));
        check("b_rsp_valid", 8'(b_rsp_valid), 8'(exp_bv));
        check("a_rsp_rdata", a_rsp_rdata, exp_av ? exp_rd : 8'h00);
        check("b_rsp_rdata", b_rsp_rdata, exp_bv ? exp_rd : 8'h00);
        check("MemRead", 8'(MemRead), 8'(acc_ph && !pend_we));
        check("MemWrite", 8'(MemWrite), 8'(acc_ph && pend_we));
        check("mem_addr", mem_addr, exp_addr);
        if (acc_ph && pend_we) check("mem_wdata", mem_wdata, pend_wd);
        check("busy", 8'(busy), 8'(pend));

        if (a_req_ready) begin a_acc_cnt++; a_acc_cyc = cyc; grants.push_back(1'b0); end
        if (b_req_ready) begin b_acc_cnt++; b_acc_cyc = cyc; grants.push_back(1'b1); end
        if (a_rsp_valid) begin
          a_rsp_cnt++; a_rd_seen = a_rsp_rdata; a_lat = cyc - a_acc_cyc; rsp_cycs.push_back(cyc);
        end
        if (b_rsp_valid) begin
          b_rsp_cnt++; b_rd_seen = b_rsp_rdata; b_lat = cyc - b_acc_cyc; rsp_cycs.push_back(cyc);
        end

        if (!reset) begin
          pend = 1'b0; exp_addr = 8'h00; last_b = 1'b1;
        end else begin
          if (rsp_ph) pend = 1'b0;
          if (ga || gb) begin
            pend     = 1'b1;
            pend_cyc = cyc;
            pend_b   = gb;
            last_b   = gb;
            pend_we  = ga ? a_req_write : b_req_write;
            exp_addr = ga ? a_req_addr : b_req_addr;
            pend_wd  = ga ? a_req_wdata : b_req_wdata;
            pend_rd  = ref_mem[exp_addr];
            if (pend_we) ref_mem[exp_addr] = pend_wd;
          end
        end
      end
    end
  end

  // Requester A: presents queued requests (or random ones), holds each until accepted.
  initial begin
    bit   acc;
    req_t r;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 8'h00; a_req_wdata = 8'h00;
    forever begin
      @(negedge clk); acc = a_req_ready;
      @(posedge clk); #1;
      if (acc) a_req_valid = 1'b0;
      if (!a_req_valid) begin
        if (aq.size() > 0) begin
          r = aq.pop_front();
          a_req_write = r.we; a_req_addr = r.addr; a_req_wdata = r.wdata; a_req_valid = 1'b1;
        end else if (rand_en && ($urandom_range(0, 2) == 0)) begin
          a_req_write = 1'($urandom_range(0, 1)); a_req_addr = 8'($urandom_range(0, 15));
          a_req_wdata = 8'($urandom); a_req_valid = 1'b1;
        end
      end
    end
  end

  // Requester B: same protocol as A.
  initial begin
    bit   acc;
    req_t r;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 8'h00; b_req_wdata = 8'h00;
    forever begin
      @(negedge clk); acc = b_req_ready;
      @(posedge clk); #1;
      if (acc) b_req_valid = 1'b0;
      if (!b_req_valid) begin
        if (bq.size() > 0) begin
          r = bq.pop_front();
          b_req_write = r.we; b_req_addr = r.addr; b_req_wdata = r.wdata; b_req_valid = 1'b1;
        end else if (rand_en && ($urandom_range(0, 2) == 0)) begin
          b_req_write = 1'($urandom_range(0, 1)); b_req_addr = 8'($urandom_range(0, 15));
          b_req_wdata = 8'($urandom); b_req_valid = 1'b1;
        end
      end
    end
  end

  // Wait (bounded) for the response counters to reach their targets.
  task automatic wait_counts(input int a_tgt, input int b_tgt);
    for (int i = 0; i < 200 && (a_rsp_cnt < a_tgt || b_rsp_cnt < b_tgt); i++) @(posedge clk);
    check("wait_a_rsp", 8'(a_rsp_cnt - a_tgt), 8'd0);
    check("wait_b_rsp", 8'(b_rsp_cnt - b_tgt), 8'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
  endtask

  initial begin
    int old_a, old_b, g0, r0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    @(posedge clk); #2 reset = 1'b1;

    // 1: A write 0x10 <= 0xAB
    old_a = a_rsp_cnt;
    aq.push_back(req_t'{1'b1, 8'h10, 8'hAB});
    wait_counts(old_a + 1, b_rsp_cnt);
    check("t1_rdata", a_rd_seen, 8'h00);
    check("t1_latency", 8'(a_lat), 8'd2);

    // 2: A read 0x10 returns the written data
    old_a = a_rsp_cnt;
    aq.push_back(req_t'{1'b0, 8'h10, 8'h00});
    wait_counts(old_a + 1, b_rsp_cnt);
    check("t2_rdata", a_rd_seen, 8'hAB);
    check("t2_latency", 8'(a_lat), 8'd2);

    // 3: simultaneous requests right after reset; A wins the first tie
    pulse_reset();
    old_a = a_rsp_cnt; old_b = b_rsp_cnt; g0 = grants.size();
    aq.push_back(req_t'{1'b0, 8'h01, 8'h00});
    bq.push_back(req_t'{1'b1, 8'h01, 8'h5C});
    wait_counts(old_a + 1, old_b + 1);
    check("t3_first_grant_b", 8'(grants[g0]), 8'd0);
    check("t3_second_grant_b", 8'(grants[g0+1]), 8'd1);
    check("t3_a_rdata", a_rd_seen, 8'h00);
    old_a = a_rsp_cnt;
    aq.push_back(req_t'{1'b0, 8'h01, 8'h00});
    wait_counts(old_a + 1, b_rsp_cnt);
    check("t3_a_reread", a_rd_seen, 8'h5C);

    // 4: both held valid for 8 grants -> strict alternation, one response per 2 cycles
    old_a = a_rsp_cnt; old_b = b_rsp_cnt; g0 = grants.size(); r0 = rsp_cycs.size();
    for (int i = 0; i < 4; i++) begin
      aq.push_back(req_t'{1'b1, 8'(8'h20 + i), 8'(8'hA0 + i)});
      bq.push_back(req_t'{1'b0, 8'(8'h20 + i), 8'h00});
    end
    wait_counts(old_a + 4, old_b + 4);
    check("t4_grant_count", 8'(grants.size() - g0), 8'd8);
    for (int i = 1; i < 8; i++) begin
      check("t4_alternate", 8'(grants[g0+i]), 8'(!grants[g0+i-1]));
      check("t4_rsp_spacing", 8'(rsp_cycs[r0+i] - rsp_cycs[r0+i-1]), 8'd2);
    end

    // 5: only B requests, 4 back-to-back accesses
    old_a = a_acc_cnt; old_b = b_rsp_cnt; g0 = grants.size(); r0 = rsp_cycs.size();
    for (int i = 0; i < 4; i++) bq.push_back(req_t'{1'b1, 8'(8'h40 + i), 8'($urandom)});
    wait_counts(a_rsp_cnt, old_b + 4);
    check("t5_a_ready_count", 8'(a_acc_cnt - old_a), 8'd0);
    for (int i = 0; i < 4; i++) check("t5_grant_b", 8'(grants[g0+i]), 8'd1);
    for (int i = 1; i < 4; i++) begin
      check("t5_rsp_spacing", 8'(rsp_cycs[r0+i] - rsp_cycs[r0+i-1]), 8'd2);
    end

    // 6: reset during the RESP cycle of an A read drops the response
    old_a = a_rsp_cnt; g0 = a_acc_cnt;
    aq.push_back(req_t'{1'b0, 8'h10, 8'h00});
    for (int i = 0; i < 50 && a_acc_cnt == g0; i++) @(posedge clk);
    check("t6_accepted", 8'(a_acc_cnt - g0), 8'd1);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check("t6_no_rsp", 8'(a_rsp_cnt - old_a), 8'd0);
    check("t6_busy_after", 8'(busy), 8'd0);
    check("t6_addr_after", mem_addr, 8'h00);
    old_a = a_rsp_cnt;
    aq.push_back(req_t'{1'b1, 8'h33, 8'h77});
    aq.push_back(req_t'{1'b0, 8'h33, 8'h00});
    wait_counts(old_a + 2, b_rsp_cnt);
    check("t6_new_rdata", a_rd_seen, 8'h77);

    // Random traffic on both ports with occasional resets.
    rand_en = 1'b1;
    repeat (1500) begin
      @(posedge clk);
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
      end
    end
    rand_en = 1'b0;
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
